direct_coupling_multi: RTL and testbench

- Time-multiplexed, parametrised multi-channel direct frequency-coupling detector.
- Compares NCH cortical oscillator OMEGA_DT values against NCH paired Schumann harmonic OMEGA_DT values, one channel per enabled cycle.
- Produces per-channel detuning, Q14 Gaussian-approximation coupling, hysteretic lock flags, and the best-coupled channel.
- Sits beside the boundary detectors and feeds arousal/state logic.

---
 rtl/direct_coupling_multi.sv | 181 ++++++++++++++++++
 tb/tb_direct_coupling_multi.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/direct_coupling_multi.sv
// Time-multiplexed multi-channel cortex/Schumann frequency-coupling detector.
// One channel per enabled cycle: |detuning| -> Gaussian-approx coupling -> lock/best tracking.
module direct_coupling_multi #(
   parameter int unsigned WIDTH    = 18,
   parameter int unsigned FRAC     = 14,
   parameter int unsigned NCH      = 4,
   parameter int unsigned CH_W     = 2,
   parameter int unsigned SIGMA    = 12,
   parameter int unsigned SCALE    = 114,
   parameter int unsigned LOCK_ON  = 8192,
   parameter int unsigned LOCK_OFF = 4096,
   parameter int unsigned LOCK_N   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_en,
   input  logic                   start,
   input  logic [NCH*WIDTH-1:0]   omega_cortex,
   input  logic [NCH*WIDTH-1:0]   omega_sr,
   output logic [NCH*WIDTH-1:0]   detuning,
   output logic [NCH*WIDTH-1:0]   coupling,
   output logic [NCH-1:0]         lock,
   output logic                   lock_any,
   output logic [CH_W-1:0]        best_ch,
   output logic [WIDTH-1:0]       best_coupling,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned ONE   = 32'd1 << FRAC;
   localparam int unsigned CNT_W = $clog2(LOCK_N) + 1;
   localparam int unsigned PW    = 2 * WIDTH + 8;
   localparam logic [WIDTH:0] MAX_D = {2'b00, {(WIDTH-1){1'b1}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]             state, state_nxt;
   logic [CH_W-1:0]        idx;
   logic [NCH*WIDTH-1:0]   snap_c, snap_s;
   logic                   s1_vld;
   logic [CH_W-1:0]        s1_ch;
   logic [WIDTH-1:0]       s1_d;
   logic [WIDTH-1:0]       run_val;
   logic [CH_W-1:0]        run_ch;
   logic [CNT_W-1:0]       cnt_q   [NCH];
   logic [CNT_W-1:0]       cnt_nxt [NCH];
   logic [NCH-1:0]         lock_nxt;

   logic signed [WIDTH-1:0] cur_c, cur_s;
   logic signed [WIDTH:0]   diff;
   logic [WIDTH:0]          absd;
   logic [WIDTH-1:0]        d_c;
   logic [PW-1:0]           prod;
   logic [WIDTH-1:0]        c_c;
   logic [WIDTH-1:0]        cand_val;
   logic [CH_W-1:0]         cand_ch;

   // Scan sequencing
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SCAN;
         S_SCAN:  if (idx == CH_W'(NCH - 1)) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         state <= S_IDLE;
      else if (clk_en) state <= state_nxt;
   end

   // Stage 1: select snapshot channel, absolute difference with saturation
   always_comb begin
      cur_c = '0;
      cur_s = '0;
      for (int i = 0; i < NCH; i++) begin
         if (idx == CH_W'(i)) begin
            cur_c = snap_c[i*WIDTH +: WIDTH];
            cur_s = snap_s[i*WIDTH +: WIDTH];
         end
      end
      diff = $signed({cur_c[WIDTH-1], cur_c}) - $signed({cur_s[WIDTH-1], cur_s});
      absd = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      d_c  = (absd > MAX_D) ? MAX_D[WIDTH-1:0] : absd[WIDTH-1:0];
   end

   // Stage 2: coupling = ONE - d^2*SCALE, clamped to [0, ONE]
   always_comb begin
      prod = PW'(s1_d) * PW'(s1_d) * PW'(SCALE);
      if (s1_d > WIDTH'(SIGMA))  c_c = '0;
      else if (prod >= PW'(ONE)) c_c = '0;
      else                       c_c = WIDTH'(PW'(ONE) - prod);
   end

   // Hysteretic lock counters; only the channel in stage 2 moves
   always_comb begin
      lock_nxt = lock;
      for (int i = 0; i < NCH; i++) begin
         cnt_nxt[i] = cnt_q[i];
         if (s1_vld && (s1_ch == CH_W'(i))) begin
            if (c_c >= WIDTH'(LOCK_ON)) begin
               if (cnt_q[i] < CNT_W'(LOCK_N)) cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
               if (cnt_nxt[i] == CNT_W'(LOCK_N)) lock_nxt[i] = 1'b1;
            end else if (c_c < WIDTH'(LOCK_OFF)) begin
               cnt_nxt[i]  = '0;
               lock_nxt[i] = 1'b0;
            end
         end
      end
   end

   // Running maximum; strict compare keeps the lowest index on ties
   always_comb begin
      cand_val = run_val;
      cand_ch  = run_ch;
      if (s1_vld && (c_c > run_val)) begin
         cand_val = c_c;
         cand_ch  = s1_ch;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx           <= '0;
         snap_c        <= '0;
         snap_s        <= '0;
         s1_vld        <= 1'b0;
         s1_ch         <= '0;
         s1_d          <= '0;
         run_val       <= '0;
         run_ch        <= '0;
         detuning      <= '0;
         coupling      <= '0;
         lock          <= '0;
         lock_any      <= 1'b0;
         best_ch       <= '0;
         best_coupling <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else if (clk_en) begin
         s1_vld <= (state == S_SCAN);
         done   <= (state == S_DRAIN);
         busy   <= (state_nxt != S_IDLE);
         if (state == S_SCAN) begin
            idx   <= idx + CH_W'(1);
            s1_ch <= idx;
            s1_d  <= d_c;
         end
         if (s1_vld) begin
            run_val <= cand_val;
            run_ch  <= cand_ch;
            for (int i = 0; i < NCH; i++) begin
               if (s1_ch == CH_W'(i)) begin
                  detuning[i*WIDTH +: WIDTH] <= s1_d;
                  coupling[i*WIDTH +: WIDTH] <= c_c;
               end
            end
         end
         if ((state == S_IDLE) && start) begin
            snap_c  <= omega_cortex;
            snap_s  <= omega_sr;
            idx     <= '0;
            run_val <= '0;
            run_ch  <= '0;
         end
         if (state == S_DRAIN) begin
            best_ch       <= cand_ch;
            best_coupling <= cand_val;
         end
         lock     <= lock_nxt;
         lock_any <= |lock_nxt;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_direct_coupling_multi.sv
// Bench for direct_coupling_multi: vector table plus hand sequences for lock, clk_en, start and reset.
`timescale 1ns/1ps
module tb_direct_coupling_multi;
   localparam int W = 18;
   localparam int N = 4;

   logic             clk, rst, clk_en, start;
   logic [N*W-1:0]   omega_cortex, omega_sr, detuning, coupling;
   logic [N-1:0]     lock;
   logic             lock_any;
   logic [1:0]       best_ch;
   logic [W-1:0]     best_coupling;
   logic             busy, done;

   direct_coupling_multi dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
      .omega_cortex(omega_cortex), .omega_sr(omega_sr),
      .detuning(detuning), .coupling(coupling), .lock(lock), .lock_any(lock_any),
      .best_ch(best_ch), .best_coupling(best_coupling), .busy(busy), .done(done)
   );

   typedef struct packed { logic [W-1:0] c, s, ed, ec; } chv_t;
   typedef struct packed { chv_t [N-1:0] ch; } vec_t;
   typedef struct packed {
      logic [N-1:0][W-1:0] ed;
      logic [N-1:0][W-1:0] ec;
      logic [N-1:0]        el;
      logic                ela;
      logic [1:0]          eb;
      logic [W-1:0]        ebc;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[4];
   vec_t lk3, lk9, lk11;
   int   n_cmp, n_bad;
   int   mcnt[N];
   bit   mlock[N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   function automatic chv_t chv(input int c, input int s, input int ed, input int ec);
      chv_t r;
      r.c = W'(c); r.s = W'(s); r.ed = W'(ed); r.ec = W'(ec);
      return r;
   endfunction

   // Expected results: per-channel values from the table, best and lock from a reference model
   task automatic make_exp(input vec_t v, output exp_t e);
      e = '0;
      for (int i = 0; i < N; i++) begin
         e.ed[i] = v.ch[i].ed;
         e.ec[i] = v.ch[i].ec;
         if (v.ch[i].ec > e.ebc) begin
            e.ebc = v.ch[i].ec;
            e.eb  = 2'(i);
         end
         if (v.ch[i].ec >= 8192) begin
            if (mcnt[i] < 4) mcnt[i]++;
            if (mcnt[i] == 4) mlock[i] = 1'b1;
         end else if (v.ch[i].ec < 4096) begin
            mcnt[i]  = 0;
            mlock[i] = 1'b0;
         end
         e.el[i] = mlock[i];
      end
      e.ela = |e.el;
   endtask

   task automatic drive_inputs(input vec_t v);
      for (int i = 0; i < N; i++) begin
         omega_cortex[i*W +: W] = v.ch[i].c;
         omega_sr[i*W +: W]     = v.ch[i].s;
      end
   endtask

   task automatic run_scan(input vec_t v, input bit toggle_en, input bit mid_start, input string tag);
      exp_t e;
      int   en_cnt, extra;
      bit   got;
      drive_inputs(v);
      make_exp(v, e);
      sbq.push_back(e);
      clk_en = 1'b1;
      start  = 1'b1;
      step();
      start = 1'b0;
      omega_cortex = {$urandom, $urandom, $urandom};
      omega_sr     = {$urandom, $urandom, $urandom};
      chk({tag, "_busy_hi"}, 64'(busy), 64'd1);
      en_cnt = 0;
      got    = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (toggle_en) clk_en = cyc[0];
         start = (mid_start && cyc == 1);
         step();
         if (clk_en) en_cnt++;
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      start  = 1'b0;
      clk_en = 1'b1;
      e = sbq.pop_front();
      chk({tag, "_done_seen"}, 64'(got), 64'd1);
      chk({tag, "_latency"}, 64'(en_cnt), 64'(N + 1));
      chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s_det%0d", tag, i), 64'(detuning[i*W +: W]), 64'(e.ed[i]));
         chk($sformatf("%s_cpl%0d", tag, i), 64'(coupling[i*W +: W]), 64'(e.ec[i]));
      end
      chk({tag, "_lock"}, 64'(lock), 64'(e.el));
      chk({tag, "_lock_any"}, 64'(lock_any), 64'(e.ela));
      chk({tag, "_best_ch"}, 64'(best_ch), 64'(e.eb));
      chk({tag, "_best_cpl"}, 64'(best_coupling), 64'(e.ebc));
      if (mid_start) begin
         extra = 0;
         for (int k = 0; k < N + 4; k++) begin
            step();
            if (done) extra++;
         end
         chk({tag, "_single_done"}, 64'(extra), 64'd0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_det"}, 64'(detuning), 64'd0);
      chk({tag, "_cpl"}, 64'(coupling), 64'd0);
      chk({tag, "_lock"}, 64'({lock, lock_any}), 64'd0);
      chk({tag, "_best"}, 64'({best_ch, best_coupling}), 64'd0);
      chk({tag, "_busy_done"}, 64'({busy, done}), 64'd0);
   endtask

   initial begin
      int ndone;
      n_cmp = 0; n_bad = 0;
      for (int i = 0; i < N; i++) begin mcnt[i] = 0; mlock[i] = 1'b0; end
      rst = 1'b1; clk_en = 1'b1; start = 1'b0;
      omega_cortex = '0; omega_sr = '0;

      // {cortex, sr, expected detuning, expected coupling} per channel
      tbl[0].ch[0] = chv(664, 643, 21, 0);
      tbl[0].ch[1] = chv(643, 643, 0, 16384);
      tbl[0].ch[2] = chv(600, 605, 5, 13534);
      tbl[0].ch[3] = chv(1000, 988, 12, 0);
      tbl[1].ch[0] = chv(100, 100, 0, 16384);
      tbl[1].ch[1] = chv(200, 210, 10, 4984);
      tbl[1].ch[2] = chv(300, 300, 0, 16384);
      tbl[1].ch[3] = chv(400, 413, 13, 0);
      tbl[2].ch[0] = chv(131071, -131072, 131071, 0);
      tbl[2].ch[1] = chv(-131072, 131071, 131071, 0);
      tbl[2].ch[2] = chv(-5, 6, 11, 2590);
      tbl[2].ch[3] = chv(-50, -47, 3, 15358);
      for (int i = 0; i < N; i++) tbl[3].ch[i] = chv(0, 100, 100, 0);

      lk3.ch[0]  = chv(603, 600, 3, 15358);
      lk9.ch[0]  = chv(609, 600, 9, 7150);
      lk11.ch[0] = chv(611, 600, 11, 2590);
      for (int i = 1; i < N; i++) begin
         lk3.ch[i]  = chv(0, 1000, 1000, 0);
         lk9.ch[i]  = chv(0, 1000, 1000, 0);
         lk11.ch[i] = chv(0, 1000, 1000, 0);
      end

      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      for (int t = 0; t < 4; t++) run_scan(tbl[t], 1'b0, 1'b0, $sformatf("vec%0d", t));

      // Lock hysteresis on channel 0
      for (int s = 1; s <= 4; s++) begin
         run_scan(lk3, 1'b0, 1'b0, $sformatf("lk3_%0d", s));
         chk($sformatf("lock0_after_scan%0d", s), 64'(lock[0]), (s == 4) ? 64'd1 : 64'd0);
      end
      run_scan(lk9, 1'b0, 1'b0, "lk9");
      chk("lock0_hold_d9", 64'(lock[0]), 64'd1);
      run_scan(lk11, 1'b0, 1'b0, "lk11");
      chk("lock0_clear_d11", 64'(lock[0]), 64'd0);
      run_scan(lk3, 1'b0, 1'b0, "lk3_restart");
      chk("lock0_counter_reset", 64'(lock[0]), 64'd0);

      run_scan(tbl[0], 1'b0, 1'b1, "midstart");
      run_scan(tbl[1], 1'b1, 1'b0, "clken_toggle");

      // Reset in the middle of a scan
      drive_inputs(tbl[2]);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      for (int i = 0; i < N; i++) begin mcnt[i] = 0; mlock[i] = 1'b0; end
      step();
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < N + 4; k++) begin
         step();
         if (done || busy) ndone++;
      end
      chk("midrst_no_done", 64'(ndone), 64'd0);
      run_scan(tbl[2], 1'b0, 1'b0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
